// File: rtl/adder_pkg.sv
// adder_pkg: shared widths and stage count for the chunked pipelined adder
package adder_pkg;
  localparam int DATA_W   = 32;
  localparam int CHUNK_W  = 8;
  localparam int N_STAGES = 4;
endpackage

// File: rtl/pipeline_adder32_if.sv
// pipeline_adder32_if: operand-in / result-out handshake bundle of the pipelined adder
interface pipeline_adder32_if;
  import adder_pkg::*;
  logic              validin;
  logic              allowin;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              cin;
  logic              out_allow;
  logic              validout;
  logic [DATA_W-1:0] sum;
  logic              cout;
  modport master (output validin, a, b, cin, out_allow, input allowin, validout, sum, cout);
  modport slave  (input validin, a, b, cin, out_allow, output allowin, validout, sum, cout);
endinterface

// File: rtl/adder_stage.sv
// adder_stage: one 8-bit slice of the pipelined adder with valid/allowin handshake and carry register
module adder_stage import adder_pkg::*; #(
  parameter int K = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic              allowin_next_i,
  output logic              allowin_o,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [DATA_W-1:0] sum_i,
  input  logic              carry_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] a_o,
  output logic [DATA_W-1:0] b_o,
  output logic [DATA_W-1:0] sum_o,
  output logic              carry_o
);
  logic              ready_go, load, valid_q, valid_d, carry_q, carry_d;
  logic [CHUNK_W:0]  part;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d, merged;
  always_comb begin
    ready_go  = 1'b1;
    allowin_o = !valid_q || (ready_go && allowin_next_i);
    load      = valid_i && allowin_o;
    valid_d   = allowin_o ? valid_i : valid_q;
    part      = {1'b0, a_i[K*CHUNK_W +: CHUNK_W]} + {1'b0, b_i[K*CHUNK_W +: CHUNK_W]}
              + {{CHUNK_W{1'b0}}, carry_i};
    merged    = sum_i;
    merged[K*CHUNK_W +: CHUNK_W] = part[CHUNK_W-1:0];
    a_d       = load ? a_i : a_q;
    b_d       = load ? b_i : b_q;
    sum_d     = load ? merged : sum_q;
    carry_d   = load ? part[CHUNK_W] : carry_q;
  end
  // only the valid bit is reset; payload is don't-care while invalid
  always_ff @(posedge clk) begin
    valid_q <= rst ? 1'b0 : valid_d;
    a_q     <= a_d;
    b_q     <= b_d;
    sum_q   <= sum_d;
    carry_q <= carry_d;
  end
  assign valid_o = valid_q;
  assign a_o     = a_q;
  assign b_o     = b_q;
  assign sum_o   = sum_q;
  assign carry_o = carry_q;
endmodule

// File: rtl/pipeline_adder32.sv
// pipeline_adder32: 32-bit adder split into four 8-bit stages, carry rippling one stage per cycle
module pipeline_adder32 import adder_pkg::*; (
  input logic                clk,
  input logic                rst,
  pipeline_adder32_if.slave  bus
);
  logic              v1, v2, v3, v4, w1, w2, w3, w4, c1, c2, c3, c4;
  logic [DATA_W-1:0] a1, a2, a3, a4, b1, b2, b3, b4, s1, s2, s3, s4;
  logic              unused;
  adder_stage #(.K(0)) u_s1 (
    .clk, .rst, .valid_i(bus.validin), .allowin_next_i(w2), .allowin_o(w1),
    .a_i(bus.a), .b_i(bus.b), .sum_i('0), .carry_i(bus.cin),
    .valid_o(v1), .a_o(a1), .b_o(b1), .sum_o(s1), .carry_o(c1)
  );
  adder_stage #(.K(1)) u_s2 (
    .clk, .rst, .valid_i(v1), .allowin_next_i(w3), .allowin_o(w2),
    .a_i(a1), .b_i(b1), .sum_i(s1), .carry_i(c1),
    .valid_o(v2), .a_o(a2), .b_o(b2), .sum_o(s2), .carry_o(c2)
  );
  adder_stage #(.K(2)) u_s3 (
    .clk, .rst, .valid_i(v2), .allowin_next_i(w4), .allowin_o(w3),
    .a_i(a2), .b_i(b2), .sum_i(s2), .carry_i(c2),
    .valid_o(v3), .a_o(a3), .b_o(b3), .sum_o(s3), .carry_o(c3)
  );
  adder_stage #(.K(N_STAGES-1)) u_s4 (
    .clk, .rst, .valid_i(v3), .allowin_next_i(bus.out_allow), .allowin_o(w4),
    .a_i(a3), .b_i(b3), .sum_i(s3), .carry_i(c3),
    .valid_o(v4), .a_o(a4), .b_o(b4), .sum_o(s4), .carry_o(c4)
  );
  // the last stage has no operand chunks left to pass on
  assign unused       = ^{a4, b4};
  assign bus.allowin  = w1;
  assign bus.validout = v4;
  assign bus.sum      = s4;
  assign bus.cout     = c4;
endmodule

// File: tb/tb_pipeline_adder32.sv
// tb_pipeline_adder32: vector table, random streams and stall/bubble/reset sequences against a queue model
module tb_pipeline_adder32;
  import adder_pkg::*;
  typedef struct { logic [31:0] a, b; logic cin; logic [31:0] s; logic co; } vec_t;
  typedef struct { logic [31:0] s; logic co; int cyc; } exp_t;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  pipeline_adder32_if bus();
  pipeline_adder32 dut (.clk(clk), .rst(rst), .bus(bus));
  vec_t        tbl[8];
  exp_t        q[$];
  int          tests = 0, fails = 0, cyc = 0, issued;
  logic [31:0] e_sum, prev_sum;
  logic        e_co, prev_co;
  bit          lat_chk, prev_stall, acc, saw_block, fresh;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  task automatic set_op(input logic [31:0] a, input logic [31:0] b, input logic cin);
    logic [32:0] full;
    full = {1'b0, a} + {1'b0, b} + {32'd0, cin};
    bus.a = a; bus.b = b; bus.cin = cin;
    e_sum = full[31:0]; e_co = full[32];
  endtask

  task automatic rand_op();
    set_op($urandom, $urandom, 1'($urandom_range(0, 1)));
  endtask

  // one cycle: inspect settled outputs at the falling edge, update the model, cross the rising edge
  task automatic step();
    exp_t e;
    @(negedge clk);
    acc = 1'b0;
    if (rst) begin
      q.delete();
      prev_stall = 1'b0;
    end else begin
      chk("allowin", bus.allowin, !(q.size() == N_STAGES && !bus.out_allow));
      if (prev_stall) begin
        chk("hold_validout", bus.validout, 1);
        chk("hold_sum", bus.sum, prev_sum);
        chk("hold_cout", bus.cout, prev_co);
      end
      prev_stall = bus.validout && !bus.out_allow;
      prev_sum = bus.sum; prev_co = bus.cout;
      if (bus.validout && bus.out_allow) begin
        if (q.size() == 0) chk("stale_validout", bus.validout, 0);
        else begin
          e = q.pop_front();
          chk("sum", bus.sum, e.s);
          chk("cout", bus.cout, e.co);
          if (lat_chk) chk("latency", cyc - e.cyc, N_STAGES);
        end
      end
      acc = bus.validin && bus.allowin;
      if (bus.validin && !bus.allowin) saw_block = 1'b1;
      if (acc) q.push_back('{e_sum, e_co, cyc});
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bus.validin = 1'b0;
    bus.out_allow = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (q.size() == 0) break;
      step();
    end
    chk("drain_empty", q.size(), 0);
  endtask

  initial begin
    tbl[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0};
    tbl[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1};
    tbl[2] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0};
    tbl[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1};
    tbl[4] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1};
    tbl[5] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0};
    tbl[6] = '{32'h00FF_00FF, 32'h0001_0001, 1'b0, 32'h0100_0100, 1'b0};
    tbl[7] = '{32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 32'h8000_0000, 1'b0};
    rst = 1'b1; bus.validin = 1'b0; bus.out_allow = 1'b1;
    bus.a = '0; bus.b = '0; bus.cin = 1'b0; e_sum = '0; e_co = 1'b0;
    lat_chk = 1'b1; prev_stall = 1'b0; saw_block = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_validout", bus.validout, 0);
    chk("rst_allowin", bus.allowin, 1);
    step();
    for (int i = 0; i < 8; i++) begin
      bus.a = tbl[i].a; bus.b = tbl[i].b; bus.cin = tbl[i].cin;
      e_sum = tbl[i].s; e_co = tbl[i].co;
      bus.validin = 1'b1;
      step();
      drain();
    end
    for (int i = 0; i < 16; i++) begin
      rand_op();
      bus.validin = 1'b1;
      step();
      chk("stream_accept", acc, 1);
    end
    drain();
    lat_chk = 1'b0; issued = 0; saw_block = 1'b0; fresh = 1'b1;
    for (int c = 1; c <= 40 && (issued < 6 || q.size() > 0); c++) begin
      bus.out_allow = !(c >= 5 && c <= 10);
      bus.validin = issued < 6;
      if (issued < 6 && fresh) begin rand_op(); fresh = 1'b0; end
      step();
      if (acc) begin issued++; fresh = 1'b1; end
    end
    chk("bp_blocked", saw_block, 1);
    chk("bp_issued", issued, 6);
    drain();
    saw_block = 1'b0; bus.out_allow = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rand_op();
      bus.validin = (i % 2 == 0);
      step();
    end
    chk("bub_held", q.size(), N_STAGES);
    chk("bub_no_block", saw_block, 0);
    rand_op();
    bus.validin = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("bub_blocked", saw_block, 1);
    bus.out_allow = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (acc) break;
    end
    chk("bub_late_accept", acc, 1);
    drain();
    lat_chk = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_op();
      bus.validin = 1'b1;
      step();
    end
    bus.validin = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_validout", bus.validout, 0);
    chk("mid_rst_allowin", bus.allowin, 1);
    for (int i = 0; i < 6; i++) step();
    set_op(32'hDEAD_BEEF, 32'h2152_4111, 1'b0);
    bus.validin = 1'b1;
    step();
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pipeline_adder32.md
PIPELINE_ADDER32 -- requirements
Module: pipeline_adder32

Interface
REQ-001 Parameter: none; data width fixed at 32 bits, split into four 8-bit chunks.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 validin  input  1  upstream offers operands this cycle.
REQ-005 allowin  output  1  adder accepts operands this cycle (stage-1 allowin).
REQ-006 a  input  32  operand A.
REQ-007 b  input  32  operand B.
REQ-008 cin  input  1  carry-in to bit 0.
REQ-009 out_allow  input  1  downstream stage can accept a result this cycle.
REQ-010 validout  output  1  result valid this cycle.
REQ-011 sum  output  32  a+b+cin modulo 2^32.
REQ-012 cout  output  1  carry out of bit 31.

Function
REQ-013 Four stages S1..S4; stage k computes sum bits [8k-1:8k-8] from a, b chunk k and the carry held from stage k-1 (cin for S1).
REQ-014 Each stage holds a valid bit, the upper operand chunks not yet added, the completed lower sum bytes and one carry bit.
REQ-015 Every stage has ready_go = 1 (single-cycle compute).
REQ-016 allowin_k = !valid_k || (ready_go_k && allowin_(k+1)); allowin_5 = out_allow; allowin = allowin_1.
REQ-017 A transfer into stage k occurs only when valid_(k-1) && allowin_k (validin && allowin for S1); the data registers of stage k load only on a transfer.
REQ-018 When allowin_k = 1, valid_k loads the upstream valid; when allowin_k = 0, valid_k and all stage-k data hold.
REQ-019 validout = valid_4; sum and cout are driven directly from S4 registers, with no combinational path from a, b or cin.
REQ-020 Latency is exactly 4 cycles from acceptance to validout with out_allow held high; throughput is 1 result per cycle.
REQ-021 While validout = 1 and out_allow = 0, sum, cout and validout hold stable until out_allow rises.
REQ-022 Full pipeline (all four valid) with out_allow = 0: allowin = 0 in the same cycle, and no operand is dropped or duplicated.
REQ-023 A bubble (validin = 0) propagates as valid = 0; a bubble stage reports allowin = 1 even when downstream is stalled, so the pipeline compresses.
REQ-024 Simultaneous accept at S1 and emit at S4 in one cycle is legal and keeps the pipeline full.
REQ-025 Overflow wraps: sum = (a+b+cin)[31:0], cout = bit 32; no saturation.

Reset
REQ-026 While rst = 1, all valid bits clear to 0 on the clock edge; validout = 0 in the cycle after rst is sampled.
REQ-027 Data registers are not reset; sum and cout are undefined while validout = 0.
REQ-028 Reset mid-operation discards all in-flight operations; allowin = 1 in the first cycle after reset.

Structure
REQ-029 Shared package adder_pkg holds DATA_W = 32, CHUNK_W = 8 and N_STAGES = 4.
REQ-030 One sub-module, adder_stage, provides one 8-bit slice: it holds the valid register, the allowin/ready_go logic and the carry register, and is instantiated four times with a chunk-index parameter.
REQ-031 Top level contains only stage instantiation, chunk routing and output assignment.

Verification
REQ-032 Single op: a = 0x0000_00FF, b = 0x0000_0001, cin = 0, out_allow = 1 -> validout high exactly 4 cycles after acceptance, sum = 0x0000_0100, cout = 0.
REQ-033 Full carry ripple: a = 0xFFFF_FFFF, b = 0x0000_0000, cin = 1 -> sum = 0x0000_0000, cout = 1.
REQ-034 Streaming: 16 back-to-back random ops with out_allow = 1 -> 16 results in order, one per cycle, each matching a reference model.
REQ-035 Backpressure: 6 back-to-back ops, out_allow = 0 for cycles 5-10 -> allowin drops once 4 ops are held, outputs are stable while stalled, and all 6 results emerge in order after release.
REQ-036 Bubbles: validin pattern 1,0,1,0 with out_allow = 0 -> pipeline compresses, allowin stays 1 until 4 valid ops are held.
REQ-037 Reset mid-flight: rst asserted for 1 cycle with 3 ops in flight -> validout = 0 next cycle, no stale result ever appears, and a new op issued after reset returns correctly after 4 cycles.
